traffic_light_ctrl_param: RTL and testbench

Next-generation two-road (main/side) traffic light controller with its own phase timer, replacing the external short/long timer and start-timer handshake.
- Adds pedestrian request latching with a walk signal, all-red clearance phases, and a night flashing mode.
- Sits between sensor/switch inputs and the lamp drivers; one instance per intersection.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/traffic_light_ctrl_param_phase_timer.sv | 35 +++
 rtl/traffic_light_ctrl_param.sv | 133 +++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the two-road traffic light controller: state encoding and
// the lamp pattern lit in each state.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    FLASH       = 3'd6
  } state_e;

  // Lamp vector order: {MR, MY, MG, SR, SY, SG}
  typedef logic [5:0] lamp_t;

  localparam lamp_t LAMP_MAIN_GREEN  = 6'b001_100;
  localparam lamp_t LAMP_MAIN_YELLOW = 6'b010_100;
  localparam lamp_t LAMP_ALL_RED     = 6'b100_100;
  localparam lamp_t LAMP_SIDE_GREEN  = 6'b100_001;
  localparam lamp_t LAMP_SIDE_YELLOW = 6'b100_010;
  localparam lamp_t LAMP_DARK        = 6'b000_000;

  // FLASH returns dark here; the top overlays the flash toggle on MY/SR.
  function automatic lamp_t lamps_of(state_e s);
    lamp_t l;
    case (s)
      MAIN_GREEN:  l = LAMP_MAIN_GREEN;
      MAIN_YELLOW: l = LAMP_MAIN_YELLOW;
      ALL_RED_1:   l = LAMP_ALL_RED;
      SIDE_GREEN:  l = LAMP_SIDE_GREEN;
      SIDE_YELLOW: l = LAMP_SIDE_YELLOW;
      ALL_RED_2:   l = LAMP_ALL_RED;
      default:     l = LAMP_DARK;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_param_phase_timer.sv
// Phase timer: counts cycles spent in the current phase. done_o flags the last
// cycle of a phase of length len_i; with sat_i the count holds there.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             sat_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign done_o = (count_q == len_i - CNT_W'(1));

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clr_i) begin
      count_d = '0;
    end else if (sat_i && done_o) begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Main/side traffic light controller with internal phase timer, pedestrian
// latch and walk lamp, all-red clearance and a night flashing mode.
module traffic_light_ctrl_param
  import traffic_pkg::*;
#(
  parameter int unsigned T_LONG     = 8,
  parameter int unsigned T_SHORT    = 2,
  parameter int unsigned T_CLEAR    = 1,
  parameter int unsigned FLASH_HALF = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       C,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] LEN_LONG  = CNT_W'(T_LONG);
  localparam logic [CNT_W-1:0] LEN_SHORT = CNT_W'(T_SHORT);
  localparam logic [CNT_W-1:0] LEN_CLEAR = CNT_W'(T_CLEAR);
  localparam logic [CNT_W-1:0] LEN_FLASH = CNT_W'(FLASH_HALF);

  state_e           state_q, state_d;
  logic             ped_q, ped_d;
  logic             walk_q, walk_d;
  logic             flash_q, flash_d;
  logic [CNT_W-1:0] tmr_len;
  logic             tmr_done;
  logic             tmr_clr;
  logic             tmr_sat;
  logic             change;
  lamp_t            lamps;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk_i  (Clk),
    .rst_i  (reset),
    .clr_i  (tmr_clr),
    .sat_i  (tmr_sat),
    .len_i  (tmr_len),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    tmr_len = LEN_LONG;
    case (state_q)
      MAIN_GREEN: begin
        tmr_len = LEN_LONG;
        if (tmr_done && (C || ped_q || night_mode)) state_d = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        tmr_len = LEN_SHORT;
        if (tmr_done) state_d = ALL_RED_1;
      end
      ALL_RED_1: begin
        tmr_len = LEN_CLEAR;
        if (tmr_done) state_d = night_mode ? FLASH : SIDE_GREEN;
      end
      SIDE_GREEN: begin
        tmr_len = LEN_LONG;
        if (tmr_done) state_d = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        tmr_len = LEN_SHORT;
        if (tmr_done) state_d = ALL_RED_2;
      end
      ALL_RED_2: begin
        tmr_len = LEN_CLEAR;
        if (tmr_done) state_d = MAIN_GREEN;
      end
      FLASH: begin
        tmr_len = LEN_FLASH;
        if (!night_mode) state_d = ALL_RED_2;
      end
      default: state_d = MAIN_GREEN;
    endcase
  end

  assign change  = (state_d != state_q);
  // In FLASH the timer restarts every half-period to pace the toggle.
  assign tmr_clr = change || ((state_q == FLASH) && tmr_done);
  assign tmr_sat = (state_q == MAIN_GREEN);

  always_comb begin
    ped_d   = ped_q | ped_req;
    walk_d  = walk_q;
    flash_d = flash_q;
    if (change && (state_d == SIDE_GREEN)) begin
      walk_d = ped_q;
      ped_d  = ped_req;
    end
    if (change && (state_d == FLASH)) begin
      flash_d = 1'b1;
    end else if ((state_q == FLASH) && tmr_done) begin
      flash_d = ~flash_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= MAIN_GREEN;
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
      walk_q  <= walk_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    lamps = lamps_of(state_q);
    if (state_q == FLASH) lamps = {1'b0, flash_q, 1'b0, flash_q, 2'b00};
  end

  assign {MR, MY, MG, SR, SY, SG} = lamps;
  assign walk  = walk_q && (state_q == SIDE_GREEN);
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Self-checking bench for traffic_light_ctrl_param: directed scenarios plus a
// long random run against a phase-level reference model.
module tb_traffic_light_ctrl_param;

  localparam int T_LONG     = 8;
  localparam int T_SHORT    = 2;
  localparam int T_CLEAR    = 1;
  localparam int FLASH_HALF = 1;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       C = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic       MR, MY, MG, SR, SY, SG, walk;
  logic [2:0] phase;

  traffic_light_ctrl_param #(
    .T_LONG     (T_LONG),
    .T_SHORT    (T_SHORT),
    .T_CLEAR    (T_CLEAR),
    .FLASH_HALF (FLASH_HALF),
    .CNT_W      (8)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .C          (C),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .MR         (MR),
    .MY         (MY),
    .MG         (MG),
    .SR         (SR),
    .SY         (SY),
    .SG         (SG),
    .walk       (walk),
    .phase      (phase)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;
  int k      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, k, $time);
  endtask

  // Reference model: phase number, cycles already spent in it, pedestrian
  // latch, walk grant for the current side green, flash lamp and its age.
  int m_ph, m_age, m_fage;
  bit m_ped, m_walk, m_flash;

  function automatic int dur(input int ph);
    case (ph)
      0, 3:    return T_LONG;
      1, 4:    return T_SHORT;
      2, 5:    return T_CLEAR;
      default: return FLASH_HALF;
    endcase
  endfunction

  function automatic logic [5:0] exp_lamps(input int ph, input bit fl);
    case (ph)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      2, 5:    return 6'b100_100;
      3:       return 6'b100_001;
      4:       return 6'b100_010;
      default: return {1'b0, fl, 1'b0, fl, 2'b00};
    endcase
  endfunction

  task automatic model_step(input bit r, input bit c, input bit p, input bit n);
    int  nxt;
    bit  last;
    if (r) begin
      m_ph = 0; m_age = 0; m_ped = 0; m_walk = 0; m_flash = 0; m_fage = 0;
      return;
    end
    last = (m_age + 1 >= dur(m_ph));
    nxt  = m_ph;
    case (m_ph)
      0: if (last && (c || m_ped || n)) nxt = 1;
      1: if (last) nxt = 2;
      2: if (last) nxt = n ? 6 : 3;
      3: if (last) nxt = 4;
      4: if (last) nxt = 5;
      5: if (last) nxt = 0;
      default: if (!n) nxt = 5;
    endcase
    if (nxt == 3 && m_ph != 3) begin
      m_walk = m_ped;
      m_ped  = p;
    end else begin
      m_ped = m_ped | p;
    end
    if (nxt == 6 && m_ph != 6) begin
      m_flash = 1; m_fage = 0;
    end else if (m_ph == 6) begin
      m_fage++;
      if (m_fage == FLASH_HALF) begin
        m_flash = ~m_flash; m_fage = 0;
      end
    end
    if (nxt != m_ph) m_age = 0;
    else if (m_ph != 0 || m_age < T_LONG - 1) m_age++;
    m_ph = nxt;
  endtask

  // Independent run-length tracking of the DUT's phase output.
  int prev_ph = 7;
  int run     = 0;
  bit run_ok  = 0;

  task automatic observe(input bit was_reset);
    logic [9:0] exp_vec;
    int         main_lit, side_lit;
    exp_vec = {exp_lamps(m_ph, m_flash), bit'(m_ph == 3 && m_walk), 3'(m_ph)};
    chk("model", {MR, MY, MG, SR, SY, SG, walk, phase}, exp_vec);
    chk("safety", (MG | MY) & (SG | SY), 0);
    if (phase != 3'd6) begin
      main_lit = int'(MR) + int'(MY) + int'(MG);
      side_lit = int'(SR) + int'(SY) + int'(SG);
      chk("one_lamp", {main_lit[7:0], side_lit[7:0]}, 16'h0101);
    end
    if (was_reset) begin
      prev_ph = 7; run_ok = 0;
    end
    if (int'(phase) == prev_ph) begin
      run++;
    end else begin
      if (run_ok) begin
        case (prev_ph)
          0:    chk("len_mg_min", run >= T_LONG, 1);
          1, 4: chk("len_yellow", run, T_SHORT);
          2, 5: chk("len_clear", run, T_CLEAR);
          3:    chk("len_sg", run, T_LONG);
          default: ;
        endcase
      end
      prev_ph = int'(phase);
      run     = 1;
      run_ok  = !was_reset || (phase == 3'd0);
    end
  endtask

  task automatic run_cycle(input bit r, input bit c, input bit p, input bit n);
    reset = r; C = c; ped_req = p; night_mode = n;
    model_step(r, c, p, n);
    @(posedge Clk);
    #1;
    if (r) k = 0;
    else k++;
    observe(r);
  endtask

  initial begin
    // Test 1: defaults, C=1 constant
    run_cycle(1, 0, 0, 0);
    chk("rst_lamps", {MR, MY, MG, SR, SY, SG}, 6'b001_100);
    chk("rst_phase", phase, 0);
    chk("rst_walk", walk, 0);
    for (int i = 0; i < 24; i++) begin
      run_cycle(0, 1, 0, 0);
      if (k == 7)  chk("t1_mg7", phase, 0);
      if (k == 8)  chk("t1_my8", phase, 1);
      if (k == 10) chk("t1_ar10", phase, 2);
      if (k == 11) chk("t1_sg11", {phase, walk}, {3'd3, 1'b0});
      if (k == 19) chk("t1_sy19", phase, 4);
      if (k == 21) chk("t1_ar21", phase, 5);
      if (k == 22) chk("t1_mg22", phase, 0);
    end

    // Test 2: ped pulse at cycle 3, C=0
    run_cycle(1, 0, 0, 0);
    for (int i = 0; i < 45; i++) begin
      run_cycle(0, 0, (k == 3), 0);
      if (k == 8)  chk("t2_my8", phase, 1);
      if (k >= 11 && k <= 18) chk("t2_walk", {phase, walk}, {3'd3, 1'b1});
      if (k == 19) chk("t2_walk_off", walk, 0);
      if (k == 45) chk("t2_hold_mg", phase, 0);
    end

    // Test 3: C rises at cycle 20
    run_cycle(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      run_cycle(0, (k >= 20), 0, 0);
      if (k == 20) chk("t3_mg20", phase, 0);
      if (k == 21) chk("t3_my21", phase, 1);
    end

    // Test 4: night mode from cycle 0, dropped at cycle 20
    run_cycle(1, 0, 0, 1);
    for (int i = 0; i < 24; i++) begin
      run_cycle(0, 0, 0, (k < 20));
      if (k == 10) chk("t4_ar10", phase, 2);
      if (k == 11) chk("t4_fl11", {phase, MY, SR}, {3'd6, 2'b11});
      if (k == 12) chk("t4_fl12", {phase, MY, SR}, {3'd6, 2'b00});
      if (k == 13) chk("t4_fl13", {phase, MY, SR}, {3'd6, 2'b11});
      if (k == 21) chk("t4_ar21", phase, 5);
      if (k == 22) chk("t4_mg22", phase, 0);
    end

    // Test 5: reset during side green at cycle 14
    run_cycle(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) run_cycle(0, 1, 0, 0);
    chk("t5_pre_sg", phase, 3);
    run_cycle(1, 1, 0, 0);
    chk("t5_rst", {MG, SR, phase, walk, MR, MY, SY, SG}, {2'b11, 3'd0, 5'b0});
    for (int i = 0; i < 9; i++) begin
      run_cycle(0, 1, 0, 0);
      if (k == 7) chk("t5_mg7", phase, 0);
      if (k == 8) chk("t5_my8", phase, 1);
    end

    // Random run
    begin
      bit n_r = 0;
      for (int i = 0; i < 10000; i++) begin
        if ($urandom_range(0, 199) == 0) n_r = ~n_r;
        run_cycle(($urandom_range(0, 1999) == 0),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 5),
                  n_r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
